// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline. Stall/flush/redirect outputs are combinational.
// Counters and ERR are registered. A memory wait freezes F..M and bubbles W.
module pipeline_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        D_VALID,
    input  logic [4:0]  D_REG_S1,
    input  logic [4:0]  D_REG_S2,
    input  logic        A_VALID,
    input  logic [6:0]  A_OPCODE,
    input  logic [4:0]  A_REG_D,
    input  logic        A_DO_JMP,
    input  logic [31:0] A_NEW_PC,
    input  logic        M_MEM_REQ,
    input  logic        M_MEM_ACK,
    output logic        F_STALL,
    output logic        D_STALL,
    output logic        A_STALL,
    output logic        M_STALL,
    output logic        W_STALL,
    output logic        D_FLUSH,
    output logic        A_FLUSH,
    output logic        M_FLUSH,
    output logic        W_FLUSH,
    output logic        NEW_PC_VALID,
    output logic [31:0] NEW_PC,
    output logic        ERR,
    output logic [31:0] STALL_CNT,
    output logic [31:0] FLUSH_CNT
);

    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_HALT     = 2'd3;

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    logic [1:0]  state_q, state_d;
    logic [15:0] init_cnt_q, init_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic mem_busy;
    logic jump;
    logic load_use;
    logic any_stall;

    always_comb begin
        mem_busy = M_MEM_REQ & ~M_MEM_ACK;
        jump     = A_VALID & A_DO_JMP;
        load_use = A_VALID & (A_OPCODE == OP_LOAD) & (A_REG_D != 5'd0) & D_VALID &
                   ((A_REG_D == D_REG_S1) | (A_REG_D == D_REG_S2));
    end

    always_comb begin
        F_STALL      = 1'b0;
        D_STALL      = 1'b0;
        A_STALL      = 1'b0;
        M_STALL      = 1'b0;
        W_STALL      = 1'b0;
        D_FLUSH      = 1'b0;
        A_FLUSH      = 1'b0;
        M_FLUSH      = 1'b0;
        W_FLUSH      = 1'b0;
        NEW_PC_VALID = 1'b0;
        NEW_PC       = 32'd0;
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        wait_cnt_d   = wait_cnt_q;

        if (RST || state_q == ST_INIT) begin
            // Pipeline latches have no reset, so keep them flushed until the counter expires.
            F_STALL = 1'b1;
            D_FLUSH = 1'b1;
            A_FLUSH = 1'b1;
            M_FLUSH = 1'b1;
            W_FLUSH = 1'b1;
            if (init_cnt_q == 16'(INIT_CYCLES - 1)) begin
                state_d    = ST_RUN;
                init_cnt_d = 16'd0;
            end else begin
                init_cnt_d = init_cnt_q + 16'd1;
            end
        end else if (state_q == ST_HALT) begin
            F_STALL = 1'b1;
            D_STALL = 1'b1;
            A_STALL = 1'b1;
            M_STALL = 1'b1;
            W_STALL = 1'b1;
        end else begin
            if (mem_busy) begin
                F_STALL = 1'b1;
                D_STALL = 1'b1;
                A_STALL = 1'b1;
                M_STALL = 1'b1;
                W_FLUSH = 1'b1;
            end else if (jump) begin
                D_FLUSH      = 1'b1;
                A_FLUSH      = 1'b1;
                NEW_PC_VALID = 1'b1;
                NEW_PC       = A_NEW_PC;
            end else if (load_use) begin
                F_STALL = 1'b1;
                D_STALL = 1'b1;
                A_FLUSH = 1'b1;
            end

            if (state_q == ST_RUN) begin
                if (mem_busy) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 16'd1;
                end
            end else if (M_MEM_ACK || !M_MEM_REQ) begin
                state_d    = ST_RUN;
                wait_cnt_d = 16'd0;
            end else if (wait_cnt_q == 16'(MEM_TIMEOUT)) begin
                state_d = ST_HALT;
            end else begin
                wait_cnt_d = wait_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        any_stall   = F_STALL | D_STALL | A_STALL | M_STALL | W_STALL;
        err_d       = err_q | (state_d == ST_HALT);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == ST_RUN || state_q == ST_MEM_WAIT) begin
            if (any_stall && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_d = stall_cnt_q + 32'd1;
            if (NEW_PC_VALID && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= 16'd0;
            wait_cnt_q  <= 16'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Registered status reads as its reset value for as long as RST is held.
    assign ERR       = err_q & ~RST;
    assign STALL_CNT = RST ? 32'd0 : stall_cnt_q;
    assign FLUSH_CNT = RST ? 32'd0 : flush_cnt_q;

endmodule
